// File: rtl/prm_edge_mask_collector_if.sv
// Handshake/bus bundle between the edge-check array, the mask collector and the graph-update logic.
interface prm_edge_mask_collector_if #(
  parameter int N_EDGES = 1024,
  parameter int IDX_W   = 10,
  parameter int CNT_W   = 11
);
  logic [N_EDGES-1:0] mask_in;
  logic               mask_vld;
  logic               busy;
  logic               out_vld;
  logic               out_rdy;
  logic [IDX_W-1:0]   out_idx;
  logic [CNT_W-1:0]   blocked_cnt;
  logic               done;

  modport master (
    input  mask_in, mask_vld, out_rdy,
    output busy, out_vld, out_idx, blocked_cnt, done
  );

  modport slave (
    output mask_in, mask_vld, out_rdy,
    input  busy, out_vld, out_idx, blocked_cnt, done
  );
endinterface

// File: rtl/prm_edge_mask_collector.sv
// Snapshots the edge_mask vector and streams blocked-edge indices in ascending order, one bit scanned per cycle.
// done arrives N_EDGES+2 cycles after capture plus one per stall; a held out_rdy freezes the scan pointer.
module prm_edge_mask_collector #(
  parameter int N_EDGES = 1024,
  parameter int IDX_W   = 10,
  parameter int CNT_W   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  prm_edge_mask_collector_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EDGES - 1);

  state_t             state_q, state_d;
  logic [N_EDGES-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic xfer;
  logic slot_free;
  logic cur_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    vld_d     = vld_q;
    idx_d     = idx_q;
    xfer      = vld_q & bus.out_rdy;
    slot_free = ~vld_q | bus.out_rdy;
    cur_bit   = snap_q[ptr_q];

    unique case (state_q)
      IDLE: begin
        if (bus.mask_vld) begin
          snap_d  = bus.mask_in;
          ptr_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (xfer) begin
          vld_d = 1'b0;
        end
        // A set bit only advances once it has a free output slot to land in.
        if (!cur_bit || slot_free) begin
          if (cur_bit) begin
            idx_d = ptr_q;
            vld_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
          if (ptr_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!vld_q || xfer) begin
          vld_d   = 1'b0;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
  assign bus.out_vld     = vld_q;
  assign bus.out_idx     = idx_q;
  assign bus.blocked_cnt = cnt_q;

endmodule

// File: tb/tb_prm_edge_mask_collector.sv
// Directed + randomized bench for prm_edge_mask_collector, checked per cycle against a transaction-level model.
module tb_prm_edge_mask_collector;
  localparam int N    = 8;
  localparam int IW   = 3;
  localparam int CW   = 4;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prm_edge_mask_collector_if #(.N_EDGES(N), .IDX_W(IW), .CNT_W(CW)) bus ();

  prm_edge_mask_collector #(.N_EDGES(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  bit rdy_pat [0:MAXC];
  bit exp_vld [0:MAXC];
  int exp_idx [0:MAXC];
  int exp_cnt [0:MAXC];
  bit exp_busy[0:MAXC];
  bit exp_done[0:MAXC];
  int exp_fin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: always ready; 1: not ready before cycle lo; 2: random, forced ready late
  task automatic set_rdy(input int mode, input int lo);
    for (int j = 0; j <= MAXC; j++) begin
      case (mode)
        0:       rdy_pat[j] = 1'b1;
        1:       rdy_pat[j] = (j >= lo);
        default: rdy_pat[j] = (j >= 40) ? 1'b1 : ($urandom_range(0, 99) < 55);
      endcase
    end
  endtask

  // Transaction view: item k (index i_k) is loaded at the end of cycle E_k, which is the later of
  // "its bit is reached" and "previous item leaves the slot"; it is accepted at the end of cycle A_k.
  task automatic model(input logic [N-1:0] m);
    int ei[$];
    int ee[$];
    int aa[$];
    int e_prev = 0;
    int i_prev = -1;
    int a_prev = 0;
    int e, a, last_exam, fin;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        e = e_prev + (i - i_prev);
        if (a_prev > e) e = a_prev;
        a = e + 1;
        while (a < MAXC && !rdy_pat[a]) a++;
        ei.push_back(i);
        ee.push_back(e);
        aa.push_back(a);
        e_prev = e;
        i_prev = i;
        a_prev = a;
      end
    end
    last_exam = e_prev + (N - 1 - i_prev);
    fin = last_exam + 2;
    if (a_prev + 1 > fin) fin = a_prev + 1;
    exp_fin = fin;
    for (int j = 0; j <= MAXC; j++) begin
      exp_vld[j]  = 1'b0;
      exp_idx[j]  = 0;
      exp_cnt[j]  = 0;
      exp_busy[j] = (j >= 1 && j <= fin);
      exp_done[j] = (j == fin);
      for (int k = 0; k < ei.size(); k++) begin
        if (ee[k] + 1 <= j) exp_cnt[j]++;
        if (ee[k] + 1 <= j && j <= aa[k]) begin
          exp_vld[j] = 1'b1;
          exp_idx[j] = ei[k];
        end
      end
    end
  endtask

  task automatic run_scan(input logic [N-1:0] m, input int want_fin, input int want_cnt, input bit junk);
    int obs_fin = -1;
    model(m);
    @(negedge clk);
    bus.mask_in  = m;
    bus.mask_vld = 1'b1;
    bus.out_rdy  = rdy_pat[0];
    for (int j = 1; j <= exp_fin + 1 && j <= MAXC; j++) begin
      @(negedge clk);
      chk($sformatf("out_vld m=%0h c=%0d", m, j), bus.out_vld, exp_vld[j]);
      if (exp_vld[j]) chk($sformatf("out_idx m=%0h c=%0d", m, j), bus.out_idx, exp_idx[j]);
      chk($sformatf("blocked_cnt m=%0h c=%0d", m, j), bus.blocked_cnt, exp_cnt[j]);
      chk($sformatf("busy m=%0h c=%0d", m, j), bus.busy, exp_busy[j]);
      chk($sformatf("done m=%0h c=%0d", m, j), bus.done, exp_done[j]);
      if (bus.done && obs_fin < 0) obs_fin = j;
      bus.out_rdy = rdy_pat[j];
      if (junk && j <= exp_fin) begin
        bus.mask_vld = 1'($urandom_range(0, 1));
        bus.mask_in  = N'($urandom);
      end else begin
        bus.mask_vld = 1'b0;
      end
    end
    bus.mask_vld = 1'b0;
    if (want_fin >= 0) chk($sformatf("done_cycle m=%0h", m), obs_fin, want_fin);
    if (want_cnt >= 0) chk($sformatf("final_cnt m=%0h", m), bus.blocked_cnt, want_cnt);
  endtask

  initial begin
    bit seen_done;
    rst          = 1'b1;
    bus.mask_in  = '0;
    bus.mask_vld = 1'b0;
    bus.out_rdy  = 1'b0;
    #12;
    chk("rst out_vld", bus.out_vld, 0);
    chk("rst out_idx", bus.out_idx, 0);
    chk("rst blocked_cnt", bus.blocked_cnt, 0);
    chk("rst done", bus.done, 0);
    chk("rst busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;

    set_rdy(0, 0);
    run_scan(8'h00, 10, 0, 1'b0);
    run_scan(8'b1000_0101, 10, 3, 1'b0);

    set_rdy(1, 5);
    run_scan(8'hFF, 13, 8, 1'b0);

    set_rdy(0, 0);
    run_scan(8'b1000_0101, 10, 3, 1'b1);
    run_scan(8'h3C, 10, 4, 1'b0);

    // asynchronous reset while an index is held in the output slot
    @(negedge clk);
    bus.mask_in  = 8'hFF;
    bus.mask_vld = 1'b1;
    bus.out_rdy  = 1'b0;
    @(negedge clk);
    bus.mask_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst out_vld", bus.out_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst out_vld", bus.out_vld, 0);
    chk("mid_rst busy", bus.busy, 0);
    chk("mid_rst blocked_cnt", bus.blocked_cnt, 0);
    chk("mid_rst done", bus.done, 0);
    chk("mid_rst out_idx", bus.out_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_rdy = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("post_rst no_done", seen_done, 0);
    chk("post_rst busy", bus.busy, 0);
    set_rdy(0, 0);
    run_scan(8'h01, 10, 1, 1'b0);

    set_rdy(1, 13);
    run_scan(8'h80, 14, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      set_rdy(2, 0);
      run_scan(N'($urandom), -1, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prm_edge_mask_collector.md
Name: prm_edge_mask_collector

Overview:
- Sits directly downstream of the per-edge `prm_oblgc_chk*` obstacle-check array.
- Captures the full vector of combinational `edge_mask` bits (1 = edge blocked by an obstacle) in one snapshot when the upstream voxel bits are stable.
- Scans the snapshot sequentially and streams the index of every blocked edge over a valid/ready interface to the PRM graph-update logic.
- Reports the total blocked-edge count and a completion pulse.

Parameters:
- N_EDGES, 1024, number of edge-check instances feeding mask_in (≥2)
- IDX_W, 10, width of an edge index; must equal ceil(log2(N_EDGES))
- CNT_W, 11, width of blocked-edge count; must equal IDX_W+1

Ports:
- clk  in  1  single system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- mask_in  in  N_EDGES  bit k = edge_mask of edge-check instance k
- mask_vld  in  1  mask_in stable; request snapshot and scan
- busy  out  1  high from capture until done pulse (inclusive)
- out_vld  out  1  out_idx holds a blocked edge index
- out_rdy  in  1  downstream accepts out_idx this cycle
- out_idx  out  IDX_W  index of blocked edge, ascending order
- blocked_cnt  out  CNT_W  number of blocked edges found in current/last scan
- done  out  1  one-cycle pulse: scan finished and last index accepted

Behaviour:
- Reset (async, active-high, immediate):
  - States: FSM=IDLE.
  - Outputs: busy=0, out_vld=0, out_idx=0, blocked_cnt=0, done=0.
  - Internals: snapshot=0, ptr=0.
- Reset mid-scan aborts the scan. No done pulse is produced and no partial state is retained.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE:
  - mask_vld=1 at a rising edge: snapshot<=mask_in, ptr<=0, blocked_cnt<=0, busy<=1, go to SCAN.
  - mask_vld with FSM not in IDLE is ignored; no queuing.
- SCAN, one snapshot bit per cycle, examining bit snapshot[ptr]:
  - The output slot is free when out_vld=0, or when out_vld=1 and out_rdy=1 in the same cycle.
  - bit=0: ptr<=ptr+1. A pending out_vld may handshake in the same cycle.
  - bit=1 and slot free: out_idx<=ptr, out_vld<=1, blocked_cnt<=blocked_cnt+1, ptr<=ptr+1.
  - bit=1 and slot not free (stall): ptr holds and nothing else changes.
  - When bit N_EDGES-1 has been consumed (ptr would pass N_EDGES-1), go to DRAIN. ptr does not wrap.
- DRAIN:
  - Wait until out_vld=0, or out_vld and out_rdy are both high (final handshake), then go to FIN.
  - If out_vld=0 on entry, leave DRAIN the next cycle.
- FIN: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
  - A mask_vld in the FIN cycle is ignored.
  - mask_vld is accepted from the first IDLE cycle after FIN.
- Handshake rules:
  - A transfer occurs on a rising edge where out_vld and out_rdy are both high.
  - out_idx is stable while out_vld=1 and out_rdy=0.
  - out_vld never drops without a transfer.
  - out_rdy may be high while out_vld=0; this has no effect.
- blocked_cnt increments when an index is loaded into the output slot, not when it is accepted. It holds its final value after done until the next capture.
- Latency: with capture at edge T, bit k is examined in cycle T+1+k.
  - With out_rdy tied high and no stalls, done is high in cycle T+N_EDGES+2.
  - Each stall cycle adds one cycle.
- Throughput: at most one index per cycle. Back-to-back blocked edges stream at one per cycle when out_rdy=1.
- Count range: all edges blocked gives blocked_cnt=N_EDGES, which fits CNT_W.

Test Plan (N_EDGES=8, IDX_W=3, CNT_W=4):
- All-zero mask, mask_vld pulse at T, out_rdy=1 → out_vld never high, done pulse at T+10, blocked_cnt=0, busy high T+1..T+10.
- mask_in=8'b1000_0101, out_rdy=1 → out_idx sequence 0,2,7 (out_vld at T+2, T+4, T+9), done at T+10, blocked_cnt=3.
- mask_in=8'hFF, out_rdy low for 3 cycles after first out_vld then high → out_idx=0 held stable 3 cycles, then 1..7 one per cycle, blocked_cnt=8, done after last accept.
- mask_vld re-asserted during SCAN with different mask → ignored; results match first snapshot; new mask_vld after done captured normally.
- rst asserted asynchronously mid-scan while out_vld=1 → out_vld, busy, blocked_cnt, done all 0 immediately; no done pulse; next mask_vld scans from index 0.
- mask_in=8'b1000_0000, out_rdy=0 until 4 cycles after out_vld → FSM sits in DRAIN, done asserted the cycle after the accepting edge, blocked_cnt=1.
